// File: rtl/queue_motion_ctrl_pkg.sv
// Shared constants, encodings and the horizontal step helper for the queue sprite sequencer.
// Screen is 640x480; y grows downward. Jump support is selected by QUEUE_JUMP_EN.
package queue_motion_ctrl_pkg;

  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;

  localparam logic [9:0] XMin     = 10'd30;
  localparam logic [9:0] XMax     = 10'(ScreenW - 1 - 30);
  localparam logic [9:0] XStart   = 10'd320;
  localparam logic [8:0] GroundY  = 9'(ScreenH - 1 - 50);
  localparam logic [9:0] Speed    = 10'd2;
  // Last value of the walk sub-counter (ANIM_FRAMES = 8)
  localparam logic [2:0] AnimLast = 3'd7;
  localparam logic signed [5:0] JumpV0 = 6'sd8;

  typedef enum logic {QueueInitial = 1'b0, QueuePlaying = 1'b1} play_state_e;
  typedef enum logic {QueueLeft = 1'b0, QueueRight = 1'b1} facing_e;
  typedef enum logic {MotionGround = 1'b0, MotionJump = 1'b1} motion_e;

  // One horizontal step, saturating to [XMin, XMax]; both/neither buttons hold position.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic go_left,
                                        input logic go_right);
    logic [9:0] nx;
    nx = x;
    if (go_left && !go_right) begin
      nx = (x <= XMin + Speed) ? XMin : x - Speed;
    end else if (go_right && !go_left) begin
      nx = (x >= XMax - Speed) ? XMax : x + Speed;
    end
    return nx;
  endfunction

endpackage

// File: rtl/queue_motion_ctrl_jump_phys.sv
// Vertical motion for the queue sprite: ground/jump FSM, signed velocity, gravity and
// landing clamp. Only instantiated when QUEUE_JUMP_EN is defined.
module queue_motion_ctrl_jump_phys
  import queue_motion_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       jump_i,
  input  logic       load_i,
  output logic [8:0] pos_y_o,
  output logic       airborne_o
);

  motion_e           mode_q, mode_d;
  logic [8:0]        pos_y_q, pos_y_d;
  logic signed [5:0] vy_q, vy_d;
  logic signed [10:0] y_next;

  // Candidate position after applying the current velocity (upward is positive vy)
  assign y_next = $signed({2'b00, pos_y_q}) - $signed({{5{vy_q[5]}}, vy_q});

  // Next-state: take off from ground, integrate while airborne, clamp on landing
  always_comb begin
    mode_d  = mode_q;
    pos_y_d = pos_y_q;
    vy_d    = vy_q;
    if (load_i) begin
      mode_d  = MotionGround;
      pos_y_d = GroundY;
      vy_d    = '0;
    end else if (tick_i) begin
      unique case (mode_q)
        MotionGround: begin
          if (jump_i) begin
            mode_d = MotionJump;
            vy_d   = JumpV0;
          end
        end
        MotionJump: begin
          // Re-pressing jump here is deliberately ignored (no double jump)
          if (y_next >= $signed({2'b00, GroundY})) begin
            mode_d  = MotionGround;
            pos_y_d = GroundY;
            vy_d    = '0;
          end else begin
            pos_y_d = y_next[8:0];
            vy_d    = vy_q - 6'sd1;
          end
        end
        default: mode_d = MotionGround;
      endcase
    end
  end

  // State registers; reset lands the sprite immediately
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MotionGround;
      pos_y_q <= GroundY;
      vy_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      pos_y_q <= pos_y_d;
      vy_q    <= vy_d;
    end
  end

  assign pos_y_o    = pos_y_q;
  assign airborne_o = (mode_q == MotionJump);

endmodule

// File: rtl/queue_motion_ctrl.sv
// Frame-rate sequencer for the queue sprite: play state, position, facing and walk phase,
// all updated once per frame_tick while playing. Jumping is built in with QUEUE_JUMP_EN.
module queue_motion_ctrl
  import queue_motion_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       btn_jump,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic       state,
  output logic       animation_state,
  output logic [1:0] walk_frame,
  output logic       airborne
);

  play_state_e state_q, state_d;
  facing_e     facing_q, facing_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [2:0]  anim_q, anim_d;
  logic [1:0]  walk_q, walk_d;
  logic        start_prev_q;

  logic       start_edge, load_start, tick_play, moved, airborne_w;
  logic [9:0] x_step;
  logic [8:0] pos_y_w;

  assign start_edge = btn_start & ~start_prev_q;
  assign load_start = (state_q == QueueInitial) & start_edge;
  assign tick_play  = frame_tick & (state_q == QueuePlaying);
  assign x_step     = step_x(pos_x_q, btn_left, btn_right);
  // A step swallowed by the wall is not a moving tick
  assign moved      = (x_step != pos_x_q);

  // Next-state: game start, horizontal step, facing and walk phase on each playing tick
  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    pos_x_d  = pos_x_q;
    anim_d   = anim_q;
    walk_d   = walk_q;
    if (load_start) begin
      state_d = QueuePlaying;
      pos_x_d = XStart;
    end else if (tick_play) begin
      pos_x_d = x_step;
      if (btn_left && !btn_right) begin
        facing_d = QueueLeft;
      end else if (btn_right && !btn_left) begin
        facing_d = QueueRight;
      end
      if (moved && !airborne_w) begin
        if (anim_q == AnimLast) begin
          anim_d = '0;
          walk_d = walk_q + 2'd1;
        end else begin
          anim_d = anim_q + 3'd1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= QueueInitial;
      facing_q     <= QueueRight;
      pos_x_q      <= XStart;
      anim_q       <= '0;
      walk_q       <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      facing_q     <= facing_d;
      pos_x_q      <= pos_x_d;
      anim_q       <= anim_d;
      walk_q       <= walk_d;
      start_prev_q <= btn_start;
    end
  end

`ifdef QUEUE_JUMP_EN
  queue_motion_ctrl_jump_phys u_jump_phys (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick_play),
    .jump_i     (btn_jump),
    .load_i     (load_start),
    .pos_y_o    (pos_y_w),
    .airborne_o (airborne_w)
  );
`else
  logic unused_btn_jump;
  assign unused_btn_jump = btn_jump;
  assign pos_y_w         = GroundY;
  assign airborne_w      = 1'b0;
`endif

  assign posX            = pos_x_q;
  assign posY            = pos_y_w;
  assign state           = state_q;
  assign animation_state = facing_q;
  assign walk_frame      = walk_q;
  assign airborne        = airborne_w;

endmodule

// File: tb/tb_queue_motion_ctrl.sv
// Scoreboard bench for queue_motion_ctrl: the driver pushes the reference model's expected
// outputs each cycle, a separate monitor pops and compares after each clock edge.
// Jump expectations follow QUEUE_JUMP_EN when it is defined for the build.
module tb_queue_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, btn_left, btn_right, btn_start, btn_jump;
  logic [9:0] posX;
  logic [8:0] posY;
  logic       state, animation_state, airborne;
  logic [1:0] walk_frame;

  always #5 clk = ~clk;

  queue_motion_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_start       (btn_start),
    .btn_jump        (btn_jump),
    .posX            (posX),
    .posY            (posY),
    .state           (state),
    .animation_state (animation_state),
    .walk_frame      (walk_frame),
    .airborne        (airborne)
  );

  typedef struct {
    int x; int y; int st; int face; int walk; int air;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain integer game rules
  int m_st, m_x, m_y, m_face, m_walk, m_anim, m_vy, m_air, m_prev;

  task automatic model_step(input bit r, input bit t, input bit l, input bit rt, input bit s,
                            input bit j);
    int dir, nx, was_air;
    if (r) begin
      m_st = 0; m_x = 320; m_y = 429; m_face = 1; m_walk = 0; m_anim = 0;
      m_vy = 0; m_air = 0; m_prev = 0;
      return;
    end
    if (m_st == 0) begin
      if (s && !m_prev) begin
        m_st = 1; m_x = 320; m_y = 429;
      end
    end else if (t) begin
      dir = (l && !rt) ? -1 : ((rt && !l) ? 1 : 0);
      nx = m_x + 2 * dir;
      if (nx < 30) nx = 30;
      if (nx > 609) nx = 609;
      if (dir < 0) m_face = 0;
      if (dir > 0) m_face = 1;
      was_air = m_air;
      if (nx != m_x && was_air == 0) begin
        m_anim++;
        if (m_anim == 8) begin
          m_anim = 0;
          m_walk = (m_walk + 1) % 4;
        end
      end
      m_x = nx;
`ifdef QUEUE_JUMP_EN
      if (was_air == 0) begin
        if (j) begin m_air = 1; m_vy = 8; end
      end else if (m_y - m_vy >= 429) begin
        m_y = 429; m_vy = 0; m_air = 0;
      end else begin
        m_y = m_y - m_vy; m_vy = m_vy - 1;
      end
`endif
    end
    m_prev = s;
  endtask

  // Drive one cycle at the falling edge, push expectation, return at the next falling edge
  task automatic cycle(input bit r, input bit t, input bit l, input bit rt, input bit s,
                       input bit j);
    exp_t e;
    rst = r; frame_tick = t; btn_left = l; btn_right = rt; btn_start = s; btn_jump = j;
    model_step(r, t, l, rt, s, j);
    e.x = m_x; e.y = m_y; e.st = m_st; e.face = m_face; e.walk = m_walk; e.air = m_air;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Tick with a quiet cycle after it so outputs must also hold between ticks
  task automatic ticks(input int n, input bit l, input bit rt, input bit j);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, l, rt, 0, j);
      cycle(0, 0, l, rt, 0, j);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every clock edge the DUT presents registered outputs; compare against queue
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.x != int'(posX) || e.y != int'(posY) || e.st != int'(state) ||
          e.face != int'(animation_state) || e.walk != int'(walk_frame) ||
          e.air != int'(airborne)) begin
        n_fail++;
        $display("FAIL sb@%0t: got x=%0d y=%0d st=%0d face=%0d walk=%0d air=%0d expected x=%0d y=%0d st=%0d face=%0d walk=%0d air=%0d",
                 $time, posX, posY, state, animation_state, walk_frame, airborne,
                 e.x, e.y, e.st, e.face, e.walk, e.air);
      end
    end
  end

  int jump_y[17] = '{421, 414, 408, 403, 399, 396, 394, 393, 393, 394, 396, 399, 403, 408,
                     414, 421, 429};

  initial begin
    int hold_l, hold_r;
    rst = 1; frame_tick = 0; btn_left = 0; btn_right = 0; btn_start = 0; btn_jump = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    check("reset_posX", int'(posX), 320);
    check("reset_state", int'(state), 0);

    // Idle in INITIAL: ticks and buttons do nothing
    ticks(3, 1, 0, 1);
    check("initial_hold_posX", int'(posX), 320);

    // Start pulse
    cycle(0, 0, 0, 0, 1, 0);
    check("start_state", int'(state), 1);
    check("start_posY", int'(posY), 429);
    cycle(0, 0, 0, 0, 0, 0);

    // Right held 10 ticks
    ticks(10, 0, 1, 0);
    check("right10_posX", int'(posX), 340);
    check("right10_walk", int'(walk_frame), 1);
    check("right10_face", int'(animation_state), 1);

    // Both buttons: no motion, facing held
    ticks(5, 1, 1, 0);
    check("both_posX", int'(posX), 340);
    check("both_face", int'(animation_state), 1);

    // Left wall, then right wall
    ticks(170, 1, 0, 0);
    check("left_wall_posX", int'(posX), 30);
    check("left_wall_face", int'(animation_state), 0);
    ticks(300, 0, 1, 0);
    check("right_wall_posX", int'(posX), 609);

    // Start edge while playing is ignored
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("restart_ignored_posX", int'(posX), 609);

    // Randomized play with held buttons, sporadic resets and restarts
    hold_l = 0; hold_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hold_l = $urandom_range(0, 1);
        hold_r = $urandom_range(0, 1);
      end
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), hold_l[0], hold_r[0],
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
    end

    // Directed jump from the ground
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    ticks(1, 0, 0, 1);
`ifdef QUEUE_JUMP_EN
    check("jump_takeoff_air", int'(airborne), 1);
    check("jump_takeoff_posY", int'(posY), 429);
    for (int i = 0; i < 17; i++) begin
      ticks(1, 0, 1, (i == 5));
      check($sformatf("jump_posY_%0d", i), int'(posY), jump_y[i]);
    end
    check("jump_landed_air", int'(airborne), 0);
    check("jump_walk_held", int'(walk_frame), 0);
`else
    check("nojump_posY", int'(posY), 429);
    check("nojump_air", int'(airborne), 0);
`endif

    // Reset mid-jump together with a tick
    ticks(1, 0, 0, 1);
    ticks(3, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 1);
    check("midjump_rst_posY", int'(posY), 429);
    check("midjump_rst_air", int'(airborne), 0);
    check("midjump_rst_posX", int'(posX), 320);
    check("midjump_rst_state", int'(state), 0);
    check("midjump_rst_face", int'(animation_state), 1);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
